// File: rtl/phase_sequencer.sv
// phase_sequencer: steps the CPU through the IF/ID/EX/MEM/WB phases.
// It provides start/halt control, memory wait states through the mem_req/mem_ready
// handshake, and skips MEM for instructions that do not need it.
// Optional macro MEM_WATCHDOG_EN bounds each memory wait to TIMEOUT cycles.
// When that bound is exceeded, the sequencer locks into FAULT until reset.
module phase_sequencer #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 halt_req,
   input  logic                 mem_access,
   input  logic                 mem_ready,
   output logic [4:0]           phase,
   output logic                 mem_req,
   output logic                 running,
   output logic                 halted,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_IF     = 3'd1,
      S_ID     = 3'd2,
      S_EX     = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6
`ifdef MEM_WATCHDOG_EN
      ,S_FAULT = 3'd7
`endif
   } state_t;

   state_t               state_q, state_d;
   logic                 halt_pend_q, halt_pend_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 in_run;

   assign in_run = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                   (state_q == S_MEM) || (state_q == S_WB);

`ifdef MEM_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wd_q, wd_d;
   logic           wd_expire;

   // The expiry flag is raised on the TIMEOUT-th consecutive wait cycle of the current IF/MEM visit.
   assign wd_expire = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready &&
                      (wd_q == WDW'(TIMEOUT - 1));

   // The wait counter runs only while IF or MEM stalls, and restarts on any state change.
   always_comb begin
      wd_d = '0;
      if (((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready && (state_d == state_q))
         wd_d = wd_q + 1'b1;
   end

   // Register the wait counter.
   always_ff @(posedge clock) begin
      if (reset) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`endif

   // Next-state logic. The halt request is latched here, and a retire increments the count.
   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      cnt_d       = cnt_q;
      if (in_run && halt_req) halt_pend_d = 1'b1;
      case (state_q)
         S_IDLE, S_HALTED: begin
            // When start and halt_req arrive together, exactly one instruction runs.
            if (start) begin
               state_d     = S_IF;
               halt_pend_d = halt_req;
            end
         end
         S_IF:  if (mem_ready) state_d = S_ID;
         S_ID:  state_d = S_EX;
         S_EX:  state_d = mem_access ? S_MEM : S_WB;
         S_MEM: if (mem_ready) state_d = S_WB;
         S_WB: begin
            cnt_d = cnt_q + 1'b1;
            if (halt_pend_q || halt_req) begin
               state_d     = S_HALTED;
               halt_pend_d = 1'b0;
            end else begin
               state_d = S_IF;
            end
         end
         default: state_d = state_q;
      endcase
`ifdef MEM_WATCHDOG_EN
      if (wd_expire) state_d = S_FAULT;
`endif
   end

   // State register, with reset taking priority over everything else.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         halt_pend_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
         cnt_q       <= cnt_d;
      end
   end

   // All outputs are decoded purely from the registered state.
   always_comb begin
      phase   = 5'b00000;
      mem_req = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      case (state_q)
         S_IF:     begin phase = 5'b00001; mem_req = 1'b1; end
         S_ID:     phase = 5'b00010;
         S_EX:     phase = 5'b00100;
         S_MEM:    begin phase = 5'b01000; mem_req = 1'b1; end
         S_WB:     phase = 5'b10000;
         S_HALTED: halted = 1'b1;
`ifdef MEM_WATCHDOG_EN
         S_FAULT:  fault = 1'b1;
`endif
         default:  phase = 5'b00000;
      endcase
   end

   assign running     = in_run;
   assign instr_count = cnt_q;

endmodule
